shift_reg_serdes: RTL and testbench



---
 rtl/shift_reg_serdes.sv | 244 ++++++++++++++++++++++++
 tb/tb_shift_reg_serdes.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_serdes.sv
// -----------------------------------------------------------------------------
// shift_reg_serdes
// Bidirectional shift-register serialiser/deserialiser with selectable bit
// order and a bit-rate clock enable.
//   Mode = 0 (SIPO): collects serial bits from SerIn into ParOut and pulses
//                    ParValid for one cycle when a word completes.
//   Mode = 1 (PISO): accepts ParIn via Load/LoadReady and shifts it out on
//                    SerOut; a Load on the last-bit cycle gives gap-free words.
//
// Optional build macro: SHIFTREG_PARITY_EN
//   Adds one parity bit per word (ODD_PARITY selects the sense) and the
//   ParityErr output in SIPO mode.
//
// Ports
//   Clock      in   rising-edge clock
//   nReset     in   asynchronous active-low reset
//   ClockEn    in   bit strobe; shifting/counting only when high
//   Mode       in   0 = SIPO, 1 = PISO
//   MsbFirst   in   1 = MSB first, 0 = LSB first
//   SerIn      in   serial data in (SIPO)
//   SerOut     out  serial data out (PISO), registered
//   ParIn      in   [BW_DATA] word to serialise
//   Load       in   load request for ParIn
//   LoadReady  out  Load is accepted this cycle (combinational)
//   ParOut     out  [BW_DATA] last deserialised word, held
//   ParValid   out  one-cycle pulse when ParOut updates
//   ParityErr  out  parity check result, valid with ParValid (macro only)
//   BitCnt     out  [clog2(BW_DATA+1)] bit position within current word
// -----------------------------------------------------------------------------
module shift_reg_serdes #(
    parameter int unsigned BW_DATA    = 24,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic                               Clock,
    input  logic                               nReset,
    input  logic                               ClockEn,
    input  logic                               Mode,
    input  logic                               MsbFirst,
    input  logic                               SerIn,
    output logic                               SerOut,
    input  logic [BW_DATA-1:0]                 ParIn,
    input  logic                               Load,
    output logic                               LoadReady,
    output logic [BW_DATA-1:0]                 ParOut,
    output logic                               ParValid,
`ifdef SHIFTREG_PARITY_EN
    output logic                               ParityErr,
`endif
    output logic [$clog2(BW_DATA+1)-1:0]       BitCnt
);

    localparam int unsigned BW_CNT  = $clog2(BW_DATA + 1);
`ifdef SHIFTREG_PARITY_EN
    localparam bit          HAS_PAR = 1'b1;
    localparam int unsigned BW_WORD = BW_DATA + 1;
`else
    localparam bit          HAS_PAR = 1'b0;
    localparam int unsigned BW_WORD = BW_DATA;
`endif
    localparam logic [BW_CNT-1:0] LAST_POS = BW_CNT'(BW_WORD - 1);
    localparam logic [BW_CNT-1:0] PAR_POS  = BW_CNT'(BW_DATA);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Registers
    state_t               r_state;
    logic [BW_DATA-1:0]   r_sr;
    logic [BW_CNT-1:0]    r_cnt;
    logic [BW_DATA-1:0]   r_par_out;
    logic                 r_par_valid;
    logic                 r_ser_out;
    logic                 r_par_bit;
    logic                 r_mode;
    logic                 r_mode_vld;
`ifdef SHIFTREG_PARITY_EN
    logic                 r_perr;
`endif

    // Next-state values
    state_t               w_state_nxt;
    logic [BW_DATA-1:0]   w_sr_nxt;
    logic [BW_CNT-1:0]    w_cnt_nxt;
    logic [BW_DATA-1:0]   w_par_out_nxt;
    logic                 w_par_valid_nxt;
    logic                 w_ser_nxt;
    logic                 w_par_bit_nxt;
`ifdef SHIFTREG_PARITY_EN
    logic                 w_perr_nxt;
`endif

    logic                 w_mode_chg;
    logic                 w_last;
    logic                 w_load;
    logic [BW_DATA-1:0]   w_sipo_shift;
    logic [BW_DATA-1:0]   w_piso_shift;

    // A mode change is only recognised once the previous mode has been sampled,
    // so a Load on the first cycle after reset is not lost.
    assign w_mode_chg   = r_mode_vld && (Mode != r_mode);
    assign w_last       = (r_cnt == LAST_POS);

    assign w_sipo_shift = MsbFirst ? {r_sr[BW_DATA-2:0], SerIn}
                                   : {SerIn, r_sr[BW_DATA-1:1]};
    assign w_piso_shift = MsbFirst ? {r_sr[BW_DATA-2:0], 1'b0}
                                   : {1'b0, r_sr[BW_DATA-1:1]};

    // Ready in IDLE, or on the final bit of a word so the next word follows gap-free
    assign LoadReady = Mode && !w_mode_chg &&
                       ((r_state == S_IDLE) ||
                        ((r_state == S_SHIFT) && ClockEn && w_last));
    assign w_load    = Load && LoadReady;

    // Next-state and datapath logic
    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_cnt_nxt       = r_cnt;
        w_par_out_nxt   = r_par_out;
        w_par_valid_nxt = 1'b0;
        w_par_bit_nxt   = r_par_bit;
`ifdef SHIFTREG_PARITY_EN
        w_perr_nxt      = r_perr;
`endif

        if (w_mode_chg) begin
            // Discard any partial word; Sr and ParOut are kept
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (!Mode) begin
            w_state_nxt = S_IDLE;
            if (ClockEn) begin
                if (HAS_PAR && (r_cnt == PAR_POS)) begin
                    // Parity bit: checked, not stored
                    w_par_out_nxt   = r_sr;
                    w_par_valid_nxt = 1'b1;
                    w_cnt_nxt       = '0;
`ifdef SHIFTREG_PARITY_EN
                    w_perr_nxt      = ((^r_sr) ^ SerIn) != ODD_PARITY;
`endif
                end else if (w_last) begin
                    w_sr_nxt        = w_sipo_shift;
                    w_par_out_nxt   = w_sipo_shift;
                    w_par_valid_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                end else begin
                    w_sr_nxt  = w_sipo_shift;
                    w_cnt_nxt = r_cnt + BW_CNT'(1);
                end
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        w_sr_nxt      = ParIn;
                        w_cnt_nxt     = '0;
                        w_par_bit_nxt = (^ParIn) ^ ODD_PARITY;
                        w_state_nxt   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ClockEn) begin
                        if (w_last) begin
                            if (w_load) begin
                                w_sr_nxt      = ParIn;
                                w_cnt_nxt     = '0;
                                w_par_bit_nxt = (^ParIn) ^ ODD_PARITY;
                            end else begin
                                w_cnt_nxt   = '0;
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_sr_nxt  = w_piso_shift;
                            w_cnt_nxt = r_cnt + BW_CNT'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // SerOut is computed from next-state values so the registered pin
    // presents each bit for exactly one bit time.
    always_comb begin
        w_ser_nxt = IDLE_LEVEL;
        if (Mode && !w_mode_chg && (w_state_nxt == S_SHIFT)) begin
            if (HAS_PAR && (w_cnt_nxt == PAR_POS)) begin
                w_ser_nxt = w_par_bit_nxt;
            end else begin
                w_ser_nxt = MsbFirst ? w_sr_nxt[BW_DATA-1] : w_sr_nxt[0];
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_ser_out   <= IDLE_LEVEL;
            r_par_bit   <= 1'b0;
            r_mode      <= 1'b0;
            r_mode_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_par_out   <= w_par_out_nxt;
            r_par_valid <= w_par_valid_nxt;
            r_ser_out   <= w_ser_nxt;
            r_par_bit   <= w_par_bit_nxt;
            r_mode      <= Mode;
            r_mode_vld  <= 1'b1;
        end
    end

`ifdef SHIFTREG_PARITY_EN
    // Parity error flag, updated together with ParOut
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_nxt;
        end
    end

    assign ParityErr = r_perr;
`endif

    assign SerOut   = r_ser_out;
    assign ParOut   = r_par_out;
    assign ParValid = r_par_valid;
    assign BitCnt   = r_cnt;

endmodule

// File: tb/tb_shift_reg_serdes.sv
// Directed bench for shift_reg_serdes with BW_DATA = 8.
module tb_shift_reg_serdes;

    localparam int unsigned BW = 8;

    logic          Clock = 1'b0;
    logic          nReset;
    logic          ClockEn;
    logic          Mode;
    logic          MsbFirst;
    logic          SerIn;
    logic          SerOut;
    logic [BW-1:0] ParIn;
    logic          Load;
    logic          LoadReady;
    logic [BW-1:0] ParOut;
    logic          ParValid;
    logic [3:0]    BitCnt;
`ifdef SHIFTREG_PARITY_EN
    logic          ParityErr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    shift_reg_serdes #(
        .BW_DATA    (BW),
        .IDLE_LEVEL (1'b0),
        .ODD_PARITY (1'b0)
    ) u_dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .ClockEn   (ClockEn),
        .Mode      (Mode),
        .MsbFirst  (MsbFirst),
        .SerIn     (SerIn),
        .SerOut    (SerOut),
        .ParIn     (ParIn),
        .Load      (Load),
        .LoadReady (LoadReady),
        .ParOut    (ParOut),
        .ParValid  (ParValid),
`ifdef SHIFTREG_PARITY_EN
        .ParityErr (ParityErr),
`endif
        .BitCnt    (BitCnt)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [8:0]  w9;

        nReset = 1'b0; ClockEn = 1'b0; Mode = 1'b0; MsbFirst = 1'b1;
        SerIn = 1'b0; ParIn = '0; Load = 1'b0;
        #12;
        chk("rst_parout",   32'(ParOut),    32'h0);
        chk("rst_parvalid", 32'(ParValid),  32'h0);
        chk("rst_bitcnt",   32'(BitCnt),    32'h0);
        chk("rst_serout",   32'(SerOut),    32'h0);
        chk("rst_lr_sipo",  32'(LoadReady), 32'h0);
        Mode = 1'b1; #1;
        chk("rst_lr_piso",  32'(LoadReady), 32'h1);
        Mode = 1'b0; #1;
        nReset = 1'b1;
        tick();

`ifndef SHIFTREG_PARITY_EN
        // SIPO, MSB first, enable always on: 1,0,1,0,0,1,0,1 -> A5
        w8 = 8'hA5; MsbFirst = 1'b1; ClockEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            SerIn = w8[7-i];
            tick();
            chk($sformatf("sipo_msb_pv%0d", i), 32'(ParValid), 32'(i == 7));
            if (i < 7) chk($sformatf("sipo_msb_cnt%0d", i), 32'(BitCnt), 32'(i + 1));
        end
        chk("sipo_msb_parout", 32'(ParOut), 32'hA5);
        chk("sipo_msb_cnt0",   32'(BitCnt), 32'h0);
        ClockEn = 1'b0;
        tick();
        chk("sipo_msb_pv_drop", 32'(ParValid), 32'h0);
        chk("sipo_msb_hold",    32'(ParOut),   32'hA5);

        // SIPO, LSB first, enable every third cycle: same stream -> A5
        MsbFirst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            SerIn = w8[7-i]; ClockEn = 1'b1;
            tick();
            chk($sformatf("sipo_lsb_pv%0d", i), 32'(ParValid), 32'(i == 7));
            ClockEn = 1'b0; SerIn = ~SerIn;
            for (int k = 0; k < 2; k++) begin
                tick();
                chk($sformatf("sipo_lsb_hold_cnt%0d_%0d", i, k), 32'(BitCnt), 32'((i == 7) ? 0 : i + 1));
                chk($sformatf("sipo_lsb_hold_pv%0d_%0d", i, k), 32'(ParValid), 32'h0);
            end
        end
        chk("sipo_lsb_parout", 32'(ParOut), 32'hA5);

        // PISO, MSB first: 3C then C3 back-to-back
        Mode = 1'b1; ClockEn = 1'b1; MsbFirst = 1'b1;
        chk("mode_chg_lr", 32'(LoadReady), 32'h0);
        tick();
        chk("piso_idle_lr",  32'(LoadReady), 32'h1);
        chk("piso_idle_so",  32'(SerOut),    32'h0);
        chk("piso_idle_cnt", 32'(BitCnt),    32'h0);
        ParIn = 8'h3C; Load = 1'b1;
        tick();
        Load = 1'b0;
        w16 = 16'h3CC3;
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("piso_b2b_so%0d", b),  32'(SerOut),    32'(w16[15-b]));
            chk($sformatf("piso_b2b_lr%0d", b),  32'(LoadReady), 32'((b == 7) || (b == 15)));
            chk($sformatf("piso_b2b_cnt%0d", b), 32'(BitCnt),    32'(b % 8));
            if (b == 7) begin
                ParIn = 8'hC3; Load = 1'b1;
            end
            tick();
            Load = 1'b0;
        end
        chk("piso_end_so",  32'(SerOut),    32'h0);
        chk("piso_end_lr",  32'(LoadReady), 32'h1);
        chk("piso_end_cnt", 32'(BitCnt),    32'h0);

        // PISO: Load mid-word ignored; ClockEn low holds the current bit
        ParIn = 8'h96; Load = 1'b1;
        tick();
        Load = 1'b0; ParIn = 8'hFF;
        w8 = 8'h96;
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("piso_mid_so%0d", b), 32'(SerOut), 32'(w8[7-b]));
            if (b == 2) begin
                ClockEn = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("piso_hold_so%0d", k),  32'(SerOut), 32'(w8[5]));
                    chk($sformatf("piso_hold_cnt%0d", k), 32'(BitCnt), 32'h2);
                end
                ClockEn = 1'b1;
            end
            if (b == 4) begin
                Load = 1'b1;
                chk("piso_mid_lr", 32'(LoadReady), 32'h0);
            end
            tick();
            Load = 1'b0;
        end
        chk("piso_mid_end_so", 32'(SerOut),    32'h0);
        chk("piso_mid_end_lr", 32'(LoadReady), 32'h1);

        // Reset mid-word in SIPO, then a full FF word
        Mode = 1'b0; MsbFirst = 1'b1; ClockEn = 1'b1;
        tick();
        chk("sipo_back_cnt", 32'(BitCnt),    32'h0);
        chk("sipo_back_lr",  32'(LoadReady), 32'h0);
        w8 = 8'b11011000;
        for (int i = 0; i < 5; i++) begin
            SerIn = w8[7-i];
            tick();
            chk($sformatf("part_pv%0d", i), 32'(ParValid), 32'h0);
        end
        chk("part_cnt", 32'(BitCnt), 32'h5);
        nReset = 1'b0;
        #2;
        chk("mid_rst_cnt",    32'(BitCnt),   32'h0);
        chk("mid_rst_parout", 32'(ParOut),   32'h0);
        chk("mid_rst_pv",     32'(ParValid), 32'h0);
        nReset = 1'b1;
        SerIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("ff_pv%0d", i), 32'(ParValid), 32'(i == 7));
        end
        chk("ff_parout", 32'(ParOut), 32'hFF);
`else
        chk("rst_perr", 32'(ParityErr), 32'h0);
        // SIPO A5 + parity 1 -> error; A5 + parity 0 -> no error
        MsbFirst = 1'b1; ClockEn = 1'b1;
        for (int p = 1; p >= 0; p--) begin
            w9 = {8'hA5, 1'(p)};
            for (int i = 0; i < 9; i++) begin
                SerIn = w9[8-i];
                tick();
                chk($sformatf("par_sipo_pv%0d_%0d", p, i), 32'(ParValid), 32'(i == 8));
            end
            chk($sformatf("par_sipo_parout%0d", p), 32'(ParOut),    32'hA5);
            chk($sformatf("par_sipo_perr%0d", p),   32'(ParityErr), 32'(p));
            chk($sformatf("par_sipo_cnt%0d", p),    32'(BitCnt),    32'h0);
        end
        // PISO A5 -> 9th bit is even parity 0
        Mode = 1'b1;
        tick();
        ParIn = 8'hA5; Load = 1'b1;
        tick();
        Load = 1'b0;
        w9 = {8'hA5, 1'b0};
        for (int b = 0; b < 9; b++) begin
            chk($sformatf("par_piso_so%0d", b), 32'(SerOut),    32'(w9[8-b]));
            chk($sformatf("par_piso_lr%0d", b), 32'(LoadReady), 32'(b == 8));
            tick();
        end
        chk("par_piso_end_so", 32'(SerOut),    32'h0);
        chk("par_piso_end_lr", 32'(LoadReady), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
